// File: rtl/vtp_fail_log_arbiter.sv
// Round-robin arbiter that funnels VTP translation-failure reports from NUM_PORTS
// sources into a shared log FIFO with saturating read/write/drop counters.
// Optional build macro VTP_FAIL_LOG_DROP_ON_FULL_EN: accept-and-drop when the log is full.
module vtp_fail_log_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 42,
    parameter int LOG_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             fail_valid,
    input  logic [NUM_PORTS-1:0]             fail_is_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  fail_addr,
    output logic [NUM_PORTS-1:0]             fail_ready,
    output logic                             log_valid,
    output logic [63:0]                      log_entry,
    input  logic                             log_pop,
    output logic [$clog2(LOG_DEPTH):0]       log_count,
    output logic [CNT_WIDTH-1:0]             csr_rd_fail_cnt,
    output logic [CNT_WIDTH-1:0]             csr_wr_fail_cnt,
    output logic [CNT_WIDTH-1:0]             csr_drop_cnt
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW    = $clog2(LOG_DEPTH);
    localparam int CW    = AW + 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_found;
    logic [7:0]            seq;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];

    logic [63:0]           mem [LOG_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_next;
    logic [CW-1:0]         count_next;
    logic                  full;
    logic                  accept_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [63:0]           new_entry;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_addr
        assign addr_arr[g] = fail_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] cand;
        j           = 0;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            cand = PTR_W'(j);
            if (!grant_found && fail_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign full = (log_count == CW'(LOG_DEPTH));

`ifdef VTP_FAIL_LOG_DROP_ON_FULL_EN
    assign accept_ok = !reset;
`else
    assign accept_ok = !reset && !full;
`endif

    assign accept = grant_found && accept_ok;
    assign push   = accept && !full;
    assign pop    = log_pop && (log_count != '0);

    always_comb begin
        fail_ready = '0;
        if (accept) fail_ready[grant_idx] = 1'b1;
    end

    assign new_entry = {fail_is_write[grant_idx], 7'(grant_idx), seq,
                        48'({addr_arr[grant_idx], 6'b0})};

    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = log_count;
        if (push && !pop)      count_next = log_count + 1'b1;
        else if (!push && pop) count_next = log_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    // log_entry is a registered copy of the head; bypass when the new head is being written now.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
            log_entry <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_ptr_next;
            log_count <= count_next;
            if (count_next != '0) begin
                if (push && (wr_ptr == rd_ptr_next)) log_entry <= new_entry;
                else                                 log_entry <= mem[rd_ptr_next];
            end
        end
    end

    assign log_valid = (log_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr          <= '0;
            seq             <= '0;
            csr_rd_fail_cnt <= '0;
            csr_wr_fail_cnt <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            seq    <= seq + 8'd1;
            if (fail_is_write[grant_idx]) begin
                if (csr_wr_fail_cnt != '1) csr_wr_fail_cnt <= csr_wr_fail_cnt + 1'b1;
            end else begin
                if (csr_rd_fail_cnt != '1) csr_rd_fail_cnt <= csr_rd_fail_cnt + 1'b1;
            end
        end
    end

`ifdef VTP_FAIL_LOG_DROP_ON_FULL_EN
    always_ff @(posedge clk) begin
        if (reset)                                     csr_drop_cnt <= '0;
        else if (accept && full && csr_drop_cnt != '1) csr_drop_cnt <= csr_drop_cnt + 1'b1;
    end
`else
    assign csr_drop_cnt = '0;
`endif

endmodule
